pipeline_hazard_ctrl: RTL and testbench

//  Interlock and sequencing controller at the decode stage of the five-stage MIPS pipe.

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/muldiv_seq_counter.sv | 75 +++++++
 rtl/pipeline_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the decode-stage pipeline controller.
//   muldiv_state_t      : MUL/DIV sequencer state (idle / operation in flight)
//   DEFAULT_MUL_CYCLES  : launch-to-result latency of MULT/MULTU
//   DEFAULT_DIV_CYCLES  : launch-to-result latency of DIV/DIVU
package pipe_ctrl_pkg;

    typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} muldiv_state_t;

    localparam int unsigned DEFAULT_MUL_CYCLES = 3;
    localparam int unsigned DEFAULT_DIV_CYCLES = 32;

endpackage

// File: rtl/muldiv_seq_counter.sv
// MUL/DIV sequencer: IDLE/BUSY FSM plus a load/decrement latency counter.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   launch    : start an operation (honoured only in IDLE)
//   is_div    : selects the divide latency for the launch
//   abort     : drop any operation in flight, return to IDLE with counter cleared
//   busy      : operation in flight
//   done      : final busy cycle (suppressed on an abort cycle)
module muldiv_seq_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = DEFAULT_MUL_CYCLES,
    parameter int unsigned DIV_CYCLES = DEFAULT_DIV_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic launch,
    input  logic is_div,
    input  logic abort,
    output logic busy,
    output logic done
);

    localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (launch) begin
                        state_d = MD_BUSY;
                        cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (cnt_q == '0) begin
                        state_d = MD_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy = (state_q == MD_BUSY);
        done = busy && (cnt_q == '0) && !abort;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage interlock and MUL/DIV sequencing controller for the five-stage pipe.
// Detects RAW hazards of the ID sources against EX/MEM destinations, sequences the
// multi-cycle MUL/DIV unit, stalls HI/LO consumers while it runs, and flushes the pipe
// (aborting MUL/DIV) on an exception.
// Build option: FORWARDING_EN -- when defined, bypass paths exist and only an EX-stage
// load-use hazard stalls; otherwise any EX or MEM RAW stalls.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   id_*                             : ID instruction sources and class
//   ex_*, mem_*                      : EX/MEM destination info (ex_mem_type marks loads)
//   exc_flush                        : exception committed in MEM
//   stall_if, stall_id, bubble_ex    : interlock controls
//   flush_all                        : squash IF/ID/EX
//   muldiv_start, muldiv_is_div      : launch pulse and operation select
//   muldiv_busy, muldiv_done         : MUL/DIV in flight / final busy cycle
`ifndef MEM_LOAD
// Normally provided by common.vh alongside the other memory-type encodings.
`define MEM_LOAD 2'b01
`endif

module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = DEFAULT_MUL_CYCLES,
    parameter int unsigned DIV_CYCLES = DEFAULT_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic       id_is_muldiv,
    input  logic       id_is_div,
    input  logic       id_reads_hilo,
    input  logic       ex_valid,
    input  logic       ex_wb_reg_en,
    input  logic [4:0] ex_wb_reg_dest,
    input  logic [1:0] ex_mem_type,
    input  logic       mem_valid,
    input  logic       mem_wb_reg_en,
    input  logic [4:0] mem_wb_reg_dest,
    input  logic       exc_flush,
    output logic       stall_if,
    output logic       stall_id,
    output logic       bubble_ex,
    output logic       flush_all,
    output logic       muldiv_start,
    output logic       muldiv_is_div,
    output logic       muldiv_busy,
    output logic       muldiv_done
);

    logic ex_raw, mem_raw, raw_stall, md_stall, launch, seq_busy, seq_done;

    // $0 is hard-wired, so a match on it is never a real dependency.
    always_comb begin
        ex_raw = id_valid && ex_valid && ex_wb_reg_en && (ex_wb_reg_dest != 5'd0) &&
                 ((id_rs_used && (id_rs == ex_wb_reg_dest)) ||
                  (id_rt_used && (id_rt == ex_wb_reg_dest)));
        mem_raw = id_valid && mem_valid && mem_wb_reg_en && (mem_wb_reg_dest != 5'd0) &&
                  ((id_rs_used && (id_rs == mem_wb_reg_dest)) ||
                   (id_rt_used && (id_rt == mem_wb_reg_dest)));
    end

`ifdef FORWARDING_EN
    // Bypass covers everything except a load whose data is not back until MEM ends.
    assign raw_stall = ex_raw && (ex_mem_type == `MEM_LOAD);
    logic unused_mem_raw;
    assign unused_mem_raw = mem_raw;
`else
    assign raw_stall = ex_raw || mem_raw;
    logic unused_mem_type;
    assign unused_mem_type = ^ex_mem_type;
`endif

    // A muldiv must also wait out the done cycle: it can only launch from IDLE.
    // HI/LO readers are released on the done cycle.
    assign md_stall = id_valid && seq_busy &&
                      (id_is_muldiv || (id_reads_hilo && !seq_done));

    assign launch = !seq_busy && id_valid && id_is_muldiv && !raw_stall && !exc_flush;

    muldiv_seq_counter #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_seq (
        .clk    (clk),
        .rst    (rst),
        .launch (launch),
        .is_div (id_is_div),
        .abort  (exc_flush),
        .busy   (seq_busy),
        .done   (seq_done)
    );

    always_comb begin
        stall_if      = 1'b0;
        stall_id      = 1'b0;
        bubble_ex     = 1'b0;
        flush_all     = 1'b0;
        muldiv_start  = 1'b0;
        muldiv_is_div = 1'b0;
        muldiv_busy   = 1'b0;
        muldiv_done   = 1'b0;
        if (!rst) begin
            muldiv_busy = seq_busy;
            muldiv_done = seq_done;
            if (exc_flush) begin
                flush_all = 1'b1;
            end else begin
                stall_if      = raw_stall || md_stall;
                stall_id      = raw_stall || md_stall;
                bubble_ex     = raw_stall || md_stall;
                muldiv_start  = launch;
                muldiv_is_div = launch && id_is_div;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam logic [1:0] LOAD_ENC = 2'b01;
    localparam int MUL_N = 3;
    localparam int DIV_N = 32;

    typedef struct packed {
        logic       rst;
        logic       id_valid;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_rs_used;
        logic       id_rt_used;
        logic       id_is_muldiv;
        logic       id_is_div;
        logic       id_reads_hilo;
        logic       ex_valid;
        logic       ex_wb_reg_en;
        logic [4:0] ex_wb_reg_dest;
        logic [1:0] ex_mem_type;
        logic       mem_valid;
        logic       mem_wb_reg_en;
        logic [4:0] mem_wb_reg_dest;
        logic       exc_flush;
    } stim_t;

    typedef struct {
        int         cyc;
        logic [7:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst, id_valid, id_rs_used, id_rt_used, id_is_muldiv, id_is_div, id_reads_hilo;
    logic ex_valid, ex_wb_reg_en, mem_valid, mem_wb_reg_en, exc_flush;
    logic [4:0] id_rs, id_rt, ex_wb_reg_dest, mem_wb_reg_dest;
    logic [1:0] ex_mem_type;
    logic stall_if, stall_id, bubble_ex, flush_all;
    logic muldiv_start, muldiv_is_div, muldiv_busy, muldiv_done;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rs_used      (id_rs_used),
        .id_rt_used      (id_rt_used),
        .id_is_muldiv    (id_is_muldiv),
        .id_is_div       (id_is_div),
        .id_reads_hilo   (id_reads_hilo),
        .ex_valid        (ex_valid),
        .ex_wb_reg_en    (ex_wb_reg_en),
        .ex_wb_reg_dest  (ex_wb_reg_dest),
        .ex_mem_type     (ex_mem_type),
        .mem_valid       (mem_valid),
        .mem_wb_reg_en   (mem_wb_reg_en),
        .mem_wb_reg_dest (mem_wb_reg_dest),
        .exc_flush       (exc_flush),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .bubble_ex       (bubble_ex),
        .flush_all       (flush_all),
        .muldiv_start    (muldiv_start),
        .muldiv_is_div   (muldiv_is_div),
        .muldiv_busy     (muldiv_busy),
        .muldiv_done     (muldiv_done)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: the operation in flight is a (start cycle, length) pair.
    int cyc      = 0;
    bit md_on    = 0;
    int md_start = 0;
    int md_len   = 0;
    bit last_stall, last_launch;

    function automatic stim_t idle_s();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic bit reads_reg(stim_t s, logic [4:0] d);
        return s.id_valid && (d != 5'd0) &&
               ((s.id_rs_used && s.id_rs == d) || (s.id_rt_used && s.id_rt == d));
    endfunction

    task automatic apply(input stim_t s);
        rst             = s.rst;
        id_valid        = s.id_valid;
        id_rs           = s.id_rs;
        id_rt           = s.id_rt;
        id_rs_used      = s.id_rs_used;
        id_rt_used      = s.id_rt_used;
        id_is_muldiv    = s.id_is_muldiv;
        id_is_div       = s.id_is_div;
        id_reads_hilo   = s.id_reads_hilo;
        ex_valid        = s.ex_valid;
        ex_wb_reg_en    = s.ex_wb_reg_en;
        ex_wb_reg_dest  = s.ex_wb_reg_dest;
        ex_mem_type     = s.ex_mem_type;
        mem_valid       = s.mem_valid;
        mem_wb_reg_en   = s.mem_wb_reg_en;
        mem_wb_reg_dest = s.mem_wb_reg_dest;
        exc_flush       = s.exc_flush;
    endtask

    // One clock cycle: drive inputs, predict this cycle's outputs, advance the model.
    task automatic step(input stim_t s);
        bit ex_hz, mem_hz, raw, busy_now, done_now, md_stall, launch, stall;
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        ex_hz  = s.ex_valid && s.ex_wb_reg_en && reads_reg(s, s.ex_wb_reg_dest);
        mem_hz = s.mem_valid && s.mem_wb_reg_en && reads_reg(s, s.mem_wb_reg_dest);
`ifdef FORWARDING_EN
        raw = ex_hz && (s.ex_mem_type == LOAD_ENC);
`else
        raw = ex_hz || mem_hz;
`endif
        busy_now = md_on && (cyc > md_start) && (cyc <= md_start + md_len);
        done_now = busy_now && (cyc == md_start + md_len);
        md_stall = s.id_valid && busy_now &&
                   (s.id_is_muldiv || (s.id_reads_hilo && !done_now));
        launch   = !s.rst && !md_on && s.id_valid && s.id_is_muldiv && !raw && !s.exc_flush;
        stall    = !s.rst && !s.exc_flush && (raw || md_stall);
        e.cyc = cyc;
        if (s.rst) e.v = 8'b0;
        else if (s.exc_flush) e.v = {3'b000, 1'b1, 2'b00, busy_now, 1'b0};
        else e.v = {stall, stall, stall, 1'b0, launch, launch && s.id_is_div,
                    busy_now, done_now};
        exp_q.push_back(e);
        last_stall  = stall;
        last_launch = launch;
        if (s.rst || s.exc_flush || done_now) md_on = 0;
        if (launch) begin
            md_on    = 1;
            md_start = cyc;
            md_len   = s.id_is_div ? DIV_N : MUL_N;
        end
        cyc++;
    endtask

    // Monitor: compare every cycle's outputs against the queued prediction.
    initial begin
        exp_t e;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {stall_if, stall_id, bubble_ex, flush_all, muldiv_start,
                       muldiv_is_div, muldiv_busy, muldiv_done};
                total++;
                if (got !== e.v) begin
                    bad++;
                    $display("FAIL outs cyc=%0d got=%b want=%b (stall_if,stall_id,bubble_ex,flush,start,is_div,busy,done)",
                             e.cyc, got, e.v);
                end
            end
        end
    end

    initial begin
        stim_t s, mfhi, mult, div;
        apply(idle_s());
        rst = 1'b1;

        s = idle_s();
        s.rst = 1'b1;
        for (int i = 0; i < 3; i++) step(s);

        // Load to $8 in EX, consumer reads rs=$8; then the load moves to MEM.
        s = idle_s();
        s.id_valid = 1; s.id_rs = 5'd8; s.id_rs_used = 1;
        s.ex_valid = 1; s.ex_wb_reg_en = 1; s.ex_wb_reg_dest = 5'd8; s.ex_mem_type = LOAD_ENC;
        step(s);
        s.ex_valid = 0; s.mem_valid = 1; s.mem_wb_reg_en = 1; s.mem_wb_reg_dest = 5'd8;
        step(s);
        step(idle_s());

        // Load to $0 never stalls.
        s = idle_s();
        s.id_valid = 1; s.id_rs = 5'd0; s.id_rs_used = 1;
        s.ex_valid = 1; s.ex_wb_reg_en = 1; s.ex_wb_reg_dest = 5'd0; s.ex_mem_type = LOAD_ENC;
        step(s);

        // ALU write $5 in EX, then MEM; consumer reads rt=$5.
        s = idle_s();
        s.id_valid = 1; s.id_rt = 5'd5; s.id_rt_used = 1;
        s.ex_valid = 1; s.ex_wb_reg_en = 1; s.ex_wb_reg_dest = 5'd5;
        step(s);
        s.ex_valid = 0; s.mem_valid = 1; s.mem_wb_reg_en = 1; s.mem_wb_reg_dest = 5'd5;
        step(s);
        step(idle_s());

        div  = idle_s(); div.id_valid = 1; div.id_is_muldiv = 1; div.id_is_div = 1;
        mult = idle_s(); mult.id_valid = 1; mult.id_is_muldiv = 1;
        mfhi = idle_s(); mfhi.id_valid = 1; mfhi.id_reads_hilo = 1;

        // DIV launch, then MFHI waits in ID until the done cycle.
        step(div);
        for (int i = 0; i < 40; i++) begin
            step(mfhi);
            if (!last_stall) break;
        end
        step(mult);
        for (int i = 0; i < 4; i++) step(idle_s());

        // MULT held behind a DIV, launching the cycle after done.
        step(div);
        for (int i = 0; i < 40; i++) begin
            step(mult);
            if (last_launch) break;
        end
        for (int i = 0; i < 5; i++) step(idle_s());

        // Exception while the DIV counter reads 10.
        step(div);
        for (int i = 0; i < 21; i++) step(idle_s());
        s = idle_s(); s.exc_flush = 1;
        step(s);
        for (int i = 0; i < 3; i++) step(idle_s());

        // Launch and exception together: nothing starts.
        s = div; s.exc_flush = 1;
        step(s);
        step(idle_s());

        // Reset in the middle of a DIV.
        step(div);
        for (int i = 0; i < 10; i++) step(idle_s());
        s = idle_s(); s.rst = 1;
        step(s);
        for (int i = 0; i < 3; i++) step(idle_s());

        // Random traffic with small register numbers to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            s = idle_s();
            s.rst             = ($urandom_range(0, 149) == 0);
            s.id_valid        = ($urandom_range(0, 3) != 0);
            s.id_rs           = 5'($urandom_range(0, 3));
            s.id_rt           = 5'($urandom_range(0, 3));
            s.id_rs_used      = 1'($urandom);
            s.id_rt_used      = 1'($urandom);
            s.id_is_muldiv    = ($urandom_range(0, 5) == 0);
            s.id_is_div       = 1'($urandom);
            s.id_reads_hilo   = !s.id_is_muldiv && ($urandom_range(0, 3) == 0);
            s.ex_valid        = 1'($urandom);
            s.ex_wb_reg_en    = 1'($urandom);
            s.ex_wb_reg_dest  = 5'($urandom_range(0, 3));
            s.ex_mem_type     = 2'($urandom);
            s.mem_valid       = 1'($urandom);
            s.mem_wb_reg_en   = 1'($urandom);
            s.mem_wb_reg_dest = 5'($urandom_range(0, 3));
            s.exc_flush       = ($urandom_range(0, 39) == 0);
            step(s);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
